// File: rtl/div_pkg.sv
// Shared definitions for the multi-cycle divider: FSM state encodings,
// handshake constants and bus widths.
package div_pkg;

    localparam int unsigned RegBus       = 32;
    localparam int unsigned DoubleRegBus = 64;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

endpackage

// File: rtl/div.sv
// Multi-cycle 32-bit restoring divider (DIV/DIVU).
// result_o = {remainder, quotient}; valid while ready_o is high.
module div
    import div_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    signed_div_i,
    input  logic [RegBus-1:0]       opdata1_i,
    input  logic [RegBus-1:0]       opdata2_i,
    input  logic                    start_i,
    input  logic                    annul_i,
    output logic [DoubleRegBus-1:0] result_o,
    output logic                    ready_o
);

    div_state_e          state_q;
    logic [5:0]          cnt_q;
    logic [RegBus-1:0]   rem_q;
    logic [RegBus-1:0]   quot_q;     // holds the dividend, shifted out as quotient bits come in
    logic [RegBus-1:0]   dvsr_q;
    logic                neg_quot_q;
    logic                neg_rem_q;
    logic [DoubleRegBus-1:0] result_q;
    logic                ready_q;

    logic [RegBus:0]     minuend;
    logic [RegBus:0]     diff;
    logic [RegBus-1:0]   rem_d;
    logic [RegBus-1:0]   quot_d;
    logic [RegBus-1:0]   op1_abs;
    logic [RegBus-1:0]   op2_abs;

    // Operand magnitudes and one restoring step of the iteration.
    always_comb begin
        op1_abs = (signed_div_i && opdata1_i[RegBus-1]) ? (~opdata1_i + 1'b1) : opdata1_i;
        op2_abs = (signed_div_i && opdata2_i[RegBus-1]) ? (~opdata2_i + 1'b1) : opdata2_i;
        minuend = {rem_q, quot_q[RegBus-1]};
        diff    = minuend - {1'b0, dvsr_q};
        rem_d   = minuend[RegBus-1:0];
        quot_d  = {quot_q[RegBus-2:0], 1'b0};
        if (!diff[RegBus]) begin
            rem_d  = diff[RegBus-1:0];
            quot_d = {quot_q[RegBus-2:0], 1'b1};
        end
    end

    // Divider FSM with registered result and ready handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= DivFree;
            cnt_q      <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            dvsr_q     <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= '0;
            ready_q    <= DivResultNotReady;
        end else begin
            case (state_q)
                DivFree: begin
                    result_q <= '0;
                    ready_q  <= DivResultNotReady;
                    if (start_i == DivStart && !annul_i) begin
                        if (opdata2_i == '0) begin
                            state_q <= DivByZero;
                        end else begin
                            state_q    <= DivOn;
                            cnt_q      <= '0;
                            rem_q      <= '0;
                            quot_q     <= op1_abs;
                            dvsr_q     <= op2_abs;
                            neg_quot_q <= signed_div_i && (opdata1_i[RegBus-1] ^ opdata2_i[RegBus-1]);
                            neg_rem_q  <= signed_div_i && opdata1_i[RegBus-1];
                        end
                    end
                end
                DivByZero: begin
                    state_q  <= DivEnd;
                    result_q <= '0;
                    ready_q  <= DivResultReady;
                end
                DivOn: begin
                    if (annul_i) begin
                        state_q <= DivFree;
                    end else if (cnt_q != 6'd32) begin
                        rem_q  <= rem_d;
                        quot_q <= quot_d;
                        cnt_q  <= cnt_q + 6'd1;
                    end else begin
                        result_q <= {neg_rem_q  ? (~rem_q  + 1'b1) : rem_q,
                                     neg_quot_q ? (~quot_q + 1'b1) : quot_q};
                        ready_q  <= DivResultReady;
                        state_q  <= DivEnd;
                    end
                end
                DivEnd: begin
                    if (start_i == DivStop) begin
                        state_q  <= DivFree;
                        result_q <= '0;
                        ready_q  <= DivResultNotReady;
                    end
                end
                default: state_q <= DivFree;
            endcase
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div.sv
// Self-checking bench for the divider: an abstract timing/arithmetic model
// checked every cycle, plus directed literal cases and randomized operations.
module tb_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int compared   = 0;
    int mismatched = 0;
    bit checking   = 0;

    always #5 clk = ~clk;

    div dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    // Reference arithmetic: truncating division, remainder takes dividend sign.
    function automatic logic [63:0] ref_div(logic [31:0] a, logic [31:0] b, logic s);
        longint n, d, q, r;
        if (b == 32'd0) return 64'h0;
        if (s) begin
            n = longint'($signed(a));
            d = longint'($signed(b));
        end else begin
            n = longint'({32'd0, a});
            d = longint'({32'd0, b});
        end
        q = n / d;
        r = n % d;
        return {r[31:0], q[31:0]};
    endfunction

    // Abstract model: an accepted op completes after 33 edges (1 if divisor is 0).
    bit          m_busy = 0;
    bit          m_zero = 0;
    bit          m_done = 0;
    int          m_left = 0;
    logic [63:0] m_res  = 64'h0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 0;
            m_done = 0;
        end else if (m_done) begin
            if (!start_i) m_done = 0;
        end else if (m_busy) begin
            if (!m_zero && annul_i) begin
                m_busy = 0;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 0;
                    m_done = 1;
                end
            end
        end else if (start_i && !annul_i) begin
            m_busy = 1;
            m_zero = (opdata2_i == 32'd0);
            m_left = m_zero ? 1 : 33;
            m_res  = ref_div(opdata1_i, opdata2_i, signed_div_i);
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (checking) begin
            compared++;
            if (ready_o !== m_done || result_o !== (m_done ? m_res : 64'h0)) begin
                mismatched++;
                $display("FAIL cycle_check t=%0t ready=%b result=%h expected ready=%b result=%h",
                         $time, ready_o, result_o, m_done, (m_done ? m_res : 64'h0));
            end
        end
    end

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act, exp);
        end
    endtask

    // Full operation: start, wait for ready, check latency/result, hold, release.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [63:0] exp, input bit toggle);
        int lat;
        lat = -1;
        opdata1_i    = a;
        opdata2_i    = b;
        signed_div_i = s;
        start_i      = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (toggle) begin
                if (n >= 5 && n < 15) start_i = n[0];
                else if (n == 15) start_i = 1'b1;
            end
            if (ready_o) begin
                lat = n - 1;
                break;
            end
        end
        chk("latency", 65'(lat), 65'((b == 32'd0) ? 1 : 33));
        chk("result", {ready_o, result_o}, {1'b1, exp});
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk("hold", {ready_o, result_o}, {1'b1, exp});
        end
        start_i = 1'b0;
        @(posedge clk);
        #1;
        chk("release", {ready_o, result_o}, 65'h0);
    endtask

    // Start an operation and annul it so the annul is sampled at edge Ek.
    task automatic annul_op(input logic [31:0] a, input logic [31:0] b, input logic s, input int k);
        opdata1_i    = a;
        opdata2_i    = b;
        signed_div_i = s;
        start_i      = 1'b1;
        @(posedge clk);
        repeat (k - 1) @(posedge clk);
        #1;
        annul_i = 1'b1;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        annul_i = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(posedge clk);
            #1;
            chk("annul_idle", {ready_o, result_o}, 65'h0);
        end
    endtask

    initial begin
        logic [31:0] a, b;
        logic        s;
        rst          = 1'b1;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        @(posedge clk);
        #1;
        checking = 1;
        @(posedge clk);
        #1;
        chk("reset_state", {ready_o, result_o}, 65'h0);
        rst = 1'b0;

        run_op(32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 0);
        run_op(-32'sd7, 32'd2, 1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD}, 0);
        run_op(32'd7, -32'sd2, 1'b1, {32'h00000001, 32'hFFFFFFFD}, 0);
        run_op(32'd5, 32'd0, 1'b0, 64'h0, 0);
        run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, {32'h0, 32'h80000000}, 0);
        run_op(32'h80000000, 32'hFFFFFFFF, 1'b0, {32'h80000000, 32'h0}, 0);

        annul_op(32'd1234, 32'd5, 1'b0, 10);
        run_op(32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 0);

        // Reset sampled at E20 of an operation.
        opdata1_i    = 32'd555;
        opdata2_i    = 32'd4;
        signed_div_i = 1'b0;
        start_i      = 1'b1;
        @(posedge clk);
        repeat (19) @(posedge clk);
        #1;
        rst     = 1'b1;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_mid_op", {ready_o, result_o}, 65'h0);
        run_op(32'hFFFFFFFF, 32'h10, 1'b0, {32'hF, 32'h0FFFFFFF}, 0);

        run_op(32'd1000, 32'd33, 1'b0, {32'd10, 32'd30}, 1);

        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = $urandom;
            s = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: b = 32'hFFFFFFFF;
                default: ;
            endcase
            if ($urandom_range(0, 4) == 0 && b != 32'd0)
                annul_op(a, b, s, int'($urandom_range(1, 33)));
            else
                run_op(a, b, s, ref_div(a, b, s), bit'($urandom_range(0, 1)));
        end

        @(negedge clk);
        checking = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
